// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt controller.
package pic_pkg;

  localparam int IR_COUNT = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  localparam logic [7:0] RESET_PRIORITY_MARKER = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_ACK1,
    ST_VEC
  } inta_state_e;

  typedef enum logic [1:0] {
    EOI_NONSPEC     = 2'b00,
    EOI_ROT_NONSPEC = 2'b01,
    EOI_SPEC        = 2'b10,
    EOI_ROT_SPEC    = 2'b11
  } eoi_cmd_e;

  function automatic logic [2:0] encode_onehot(input logic [7:0] v);
    logic [2:0] enc;
    enc = 3'd0;
    for (int i = 0; i < IR_COUNT; i++) begin
      if (v[i]) enc = 3'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/rotating_priority_finder.sv
// Picks the highest-priority set bit, starting one past the marker.
module rotating_priority_finder
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [7:0] marker,
  output logic [7:0] grant
);

  logic [2:0] ptr;
  logic [2:0] idx;
  logic       hit;

  assign ptr = encode_onehot(marker);

  always_comb begin
    grant = 8'h00;
    hit   = 1'b0;
    idx   = 3'd0;
    for (int i = 1; i <= IR_COUNT; i++) begin
      idx = ptr + 3'(i);
      if (!hit && vec[idx]) begin
        grant[idx] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// INTA handshake, in-service register and EOI/rotation control.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int VECTOR_LEVEL_BITS = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             interrupt,
  input  logic                   interrupt_acknowledge,
  input  logic [4:0]             vector_base,
  input  logic                   auto_eoi,
  input  logic                   rotate_in_auto_eoi,
  input  logic                   eoi_strobe,
  input  logic                   eoi_specific,
  input  logic                   eoi_rotate,
  input  logic [2:0]             eoi_level,
  output logic                   int_out,
  output logic [7:0]             in_service_register,
  output logic [7:0]             highest_level_in_service,
  output logic [7:0]             clear_irr,
  output logic [7:0]             data_out,
  output logic                   data_out_en
);

  inta_state_e state_q, state_d;
  logic        inta_q;
  logic [VECTOR_LEVEL_BITS-1:0] level_q, level_d;
  logic        spur_q, spur_d;
  logic        int_out_q, int_out_d;
  logic [7:0]  isr_q, isr_d;
  logic [7:0]  marker_q, marker_d;
  logic [7:0]  clear_irr_q, clear_irr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_out_en_q, data_out_en_d;

  logic        rise, fall, no_req;
  logic [7:0]  nonspec_hit;
  logic [7:0]  inta_set, aeoi_clr, eoi_clr;
  logic        aeoi_rot, eoi_rot;
  logic [7:0]  eoi_marker;
  logic [7:0]  level_onehot;

  assign rise = interrupt_acknowledge & ~inta_q;
  assign fall = ~interrupt_acknowledge & inta_q;
  assign no_req = ~|interrupt;
  assign level_onehot = 8'b1 << level_q;

  rotating_priority_finder u_finder (
    .vec    (isr_q),
    .marker (marker_q),
    .grant  (nonspec_hit)
  );

  always_comb begin
    eoi_clr    = 8'h00;
    eoi_rot    = 1'b0;
    eoi_marker = marker_q;
    if (eoi_strobe) begin
      unique case ({eoi_specific, eoi_rotate})
        EOI_NONSPEC: eoi_clr = nonspec_hit;
        EOI_ROT_NONSPEC: begin
          eoi_clr    = nonspec_hit;
          eoi_rot    = |nonspec_hit;
          eoi_marker = nonspec_hit;
        end
        EOI_SPEC: eoi_clr = 8'b1 << eoi_level;
        EOI_ROT_SPEC: begin
          eoi_clr    = 8'b1 << eoi_level;
          eoi_rot    = 1'b1;
          eoi_marker = 8'b1 << eoi_level;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    spur_d        = spur_q;
    int_out_d     = int_out_q;
    clear_irr_d   = 8'h00;
    data_out_d    = data_out_q;
    data_out_en_d = data_out_en_q;
    inta_set      = 8'h00;
    aeoi_clr      = 8'h00;
    aeoi_rot      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!no_req) begin
          state_d   = ST_PEND;
          int_out_d = 1'b1;
        end
      end
      ST_PEND: begin
        int_out_d = 1'b1;
        if (rise) begin
          spur_d    = no_req;
          level_d   = no_req ? SPURIOUS_LEVEL
                             : encode_onehot(interrupt);
          if (!no_req) begin
            inta_set    = interrupt;
            clear_irr_d = interrupt;
          end
          int_out_d = 1'b0;
          state_d   = ST_ACK1;
        end
      end
      ST_ACK1: begin
        if (rise) begin
          state_d       = ST_VEC;
          data_out_en_d = 1'b1;
          data_out_d    = {vector_base, level_q};
        end
      end
      ST_VEC: begin
        data_out_d = {vector_base, level_q};
        if (fall) begin
          data_out_en_d = 1'b0;
          data_out_d    = 8'h00;
          state_d       = ST_IDLE;
          if (auto_eoi && !spur_q) begin
            aeoi_clr = level_onehot;
            aeoi_rot = rotate_in_auto_eoi;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clears use the pre-edge ISR; a same-cycle INTA set wins.
  always_comb begin
    isr_d    = (isr_q & ~eoi_clr & ~aeoi_clr) | inta_set;
    marker_d = marker_q;
    if (aeoi_rot) marker_d = level_onehot;
    if (eoi_rot)  marker_d = eoi_marker;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      inta_q        <= 1'b0;
      level_q       <= '0;
      spur_q        <= 1'b0;
      int_out_q     <= 1'b0;
      isr_q         <= 8'h00;
      marker_q      <= RESET_PRIORITY_MARKER;
      clear_irr_q   <= 8'h00;
      data_out_q    <= 8'h00;
      data_out_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inta_q        <= interrupt_acknowledge;
      level_q       <= level_d;
      spur_q        <= spur_d;
      int_out_q     <= int_out_d;
      isr_q         <= isr_d;
      marker_q      <= marker_d;
      clear_irr_q   <= clear_irr_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
    end
  end

  assign int_out                  = int_out_q;
  assign in_service_register      = isr_q;
  assign highest_level_in_service = marker_q;
  assign clear_irr                = clear_irr_q;
  assign data_out                 = data_out_q;
  assign data_out_en              = data_out_en_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed scoreboard bench for inta_sequencer.
module tb_inta_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] interrupt;
  logic       interrupt_acknowledge;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       rotate_in_auto_eoi;
  logic       eoi_strobe;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_out_en;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  inta_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt                (interrupt),
    .interrupt_acknowledge    (interrupt_acknowledge),
    .vector_base              (vector_base),
    .auto_eoi                 (auto_eoi),
    .rotate_in_auto_eoi       (rotate_in_auto_eoi),
    .eoi_strobe               (eoi_strobe),
    .eoi_specific             (eoi_specific),
    .eoi_rotate               (eoi_rotate),
    .eoi_level                (eoi_level),
    .int_out                  (int_out),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .clear_irr                (clear_irr),
    .data_out                 (data_out),
    .data_out_en              (data_out_en)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic eoi(input logic s, input logic r, input logic [2:0] l);
    eoi_strobe = 1'b1;
    eoi_specific = s;
    eoi_rotate = r;
    eoi_level = l;
    step();
    eoi_strobe = 1'b0;
  endtask

  task automatic ack(input logic [7:0] irq, input logic [7:0] vec);
    interrupt = irq;
    step();
    interrupt_acknowledge = 1'b1;
    step();
    interrupt = 8'h00;
    interrupt_acknowledge = 1'b0;
    step();
    interrupt_acknowledge = 1'b1;
    exp_q.push_back(vec);
    exp_q.push_back(8'h01);
    step();
    cmp("ack_vec", data_out);
    cmp("ack_en", {7'd0, data_out_en});
    interrupt_acknowledge = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    interrupt = 8'h00;
    interrupt_acknowledge = 1'b0;
    vector_base = 5'h10;
    auto_eoi = 1'b0;
    rotate_in_auto_eoi = 1'b0;
    eoi_strobe = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate = 1'b0;
    eoi_level = 3'd0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    step();
    step();
    reset = 1'b0;
    cmp("rst_int", {7'd0, int_out});
    cmp("rst_isr", in_service_register);
    cmp("rst_mark", highest_level_in_service);
    cmp("rst_en", {7'd0, data_out_en});
    cmp("rst_clr", clear_irr);

    // Basic IR2 cycle
    interrupt = 8'h04;
    exp_q.push_back(8'h01);
    step();
    cmp("int_out_up", {7'd0, int_out});
    interrupt_acknowledge = 1'b1;
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h00);
    step();
    cmp("isr_set", in_service_register);
    cmp("clr_pulse", clear_irr);
    cmp("int_out_dn", {7'd0, int_out});
    interrupt = 8'h00;
    exp_q.push_back(8'h00);
    step();
    cmp("clr_gone", clear_irr);
    interrupt_acknowledge = 1'b0;
    exp_q.push_back(8'h00);
    step();
    cmp("ack1_fall", {7'd0, data_out_en});
    interrupt_acknowledge = 1'b1;
    exp_q.push_back(8'h82);
    exp_q.push_back(8'h01);
    step();
    cmp("vec82", data_out);
    cmp("vec_en", {7'd0, data_out_en});
    interrupt_acknowledge = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h04);
    step();
    cmp("vec_off", {7'd0, data_out_en});
    cmp("isr_keep", in_service_register);

    // Build ISR = 0A and exercise non-specific EOIs
    exp_q.push_back(8'h00);
    eoi(1'b1, 1'b0, 3'd2);
    cmp("spec_eoi", in_service_register);
    ack(8'h02, 8'h81);
    ack(8'h08, 8'h83);
    exp_q.push_back(8'h0A);
    cmp("isr_0a", in_service_register);
    exp_q.push_back(8'h08);
    eoi(1'b0, 1'b0, 3'd0);
    cmp("nonspec", in_service_register);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h08);
    eoi(1'b0, 1'b1, 3'd0);
    cmp("rot_ns_isr", in_service_register);
    cmp("rot_ns_mark", highest_level_in_service);
    exp_q.push_back(8'h08);
    eoi(1'b0, 1'b1, 3'd0);
    cmp("rot_ns_empty", highest_level_in_service);

    // Automatic EOI with rotation on IR5
    auto_eoi = 1'b1;
    rotate_in_auto_eoi = 1'b1;
    ack(8'h20, 8'h85);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h20);
    cmp("aeoi_isr", in_service_register);
    cmp("aeoi_mark", highest_level_in_service);
    auto_eoi = 1'b0;
    rotate_in_auto_eoi = 1'b0;

    // Spurious request
    interrupt = 8'h02;
    step();
    interrupt = 8'h00;
    exp_q.push_back(8'h01);
    step();
    cmp("spur_int", {7'd0, int_out});
    interrupt_acknowledge = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    step();
    cmp("spur_isr", in_service_register);
    cmp("spur_clr", clear_irr);
    interrupt_acknowledge = 1'b0;
    step();
    interrupt_acknowledge = 1'b1;
    exp_q.push_back(8'h87);
    step();
    cmp("spur_vec", data_out);
    interrupt_acknowledge = 1'b0;
    step();

    // Specific rotate on empty ISR sets priority
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    eoi(1'b1, 1'b1, 3'd3);
    cmp("setpri_mark", highest_level_in_service);
    cmp("setpri_isr", in_service_register);

    // Reset during VEC
    interrupt = 8'h01;
    step();
    interrupt_acknowledge = 1'b1;
    step();
    interrupt = 8'h00;
    interrupt_acknowledge = 1'b0;
    step();
    interrupt_acknowledge = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    step();
    cmp("pre_rst_en", {7'd0, data_out_en});
    cmp("pre_rst_isr", in_service_register);
    reset = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    step();
    cmp("mid_rst_en", {7'd0, data_out_en});
    cmp("mid_rst_isr", in_service_register);
    cmp("mid_rst_mark", highest_level_in_service);
    reset = 1'b0;
    interrupt_acknowledge = 1'b0;
    interrupt = 8'h40;
    exp_q.push_back(8'h01);
    step();
    cmp("post_rst_idle", {7'd0, int_out});

    if (exp_q.size() != 0) begin
      n_bad++;
      $error("FAIL leftover: observed %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
